// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Packs a valid/ready byte stream MSB-first into instruction words
//            and writes them to consecutive instruction-memory addresses.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int DATA_LENGTH = 32,
  parameter int MEM_LENGTH  = 32,
  localparam int AW  = (MEM_LENGTH > 1) ? $clog2(MEM_LENGTH) : 1,
  localparam int WCW = $clog2(MEM_LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [7:0]             i_byte_in,
  input  logic                   i_byte_valid,
  output logic                   o_byte_ready,
  output logic                   o_wr_en,
  output logic [AW-1:0]          o_wr_addr,
  output logic [DATA_LENGTH-1:0] o_wr_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [WCW-1:0]         o_word_count
);

  localparam int BYTES = DATA_LENGTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [AW-1:0]  C_LAST_ADDR = AW'(MEM_LENGTH - 1);
  localparam logic [BCW-1:0] C_LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [DATA_LENGTH-1:0] r_asm;
  logic [DATA_LENGTH-1:0] r_wr_data;
  logic [BCW-1:0]         r_byte_cnt;
  logic [AW-1:0]          r_wr_addr;
  logic [WCW-1:0]         r_word_count;
  logic                   r_byte_ready;
  logic                   r_wr_en;
  logic                   r_busy;
  logic                   r_done;
  logic [DATA_LENGTH-1:0] w_asm_next;

  // Oldest byte falls off the top, so the first byte of a word ends up in the MSBs.
  assign w_asm_next = (r_asm << 8) | DATA_LENGTH'(i_byte_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_asm        <= '0;
      r_wr_data    <= '0;
      r_byte_cnt   <= '0;
      r_wr_addr    <= '0;
      r_word_count <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_wr_addr    <= '0;
            r_byte_cnt   <= '0;
            r_asm        <= '0;
            r_word_count <= '0;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_byte_valid) begin
            r_asm <= w_asm_next;
            if (r_byte_cnt == C_LAST_BYTE) begin
              r_wr_data    <= w_asm_next;
              r_byte_cnt   <= '0;
              r_byte_ready <= 1'b0;
              r_wr_en      <= 1'b1;
              r_state      <= S_WRITE;
            end else begin
              r_byte_cnt <= r_byte_cnt + BCW'(1);
            end
          end
        end
        S_WRITE: begin
          r_wr_en      <= 1'b0;
          r_word_count <= r_word_count + WCW'(1);
          // Terminal compare rather than wrap, so non-power-of-two depths stop exactly.
          if (r_wr_addr == C_LAST_ADDR) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wr_addr    <= r_wr_addr + AW'(1);
            r_byte_ready <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_word_count = r_word_count;

endmodule
`default_nettype wire
